// File: rtl/usart_pkg.sv
// Shared USART definitions: parity modes, FSM state encoding, baud math
// and the legal-parameter check used by both the transmitter and receiver.
package usart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Wide enough to count up to 9 data bits or 2 stop bits.
  localparam int BIT_CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } usart_state_e;

  function automatic int clks_per_bit(input longint clk_freq, input longint baud_rate);
    return int'(clk_freq / baud_rate);
  endfunction

  function automatic bit usart_params_ok(input int cpb, input int data_bit,
                                         input int parity, input int stop_bits);
    return (cpb >= 2) && (data_bit >= 5) && (data_bit <= 9) &&
           (parity >= PAR_NONE) && (parity <= PAR_EVEN) &&
           (stop_bits >= 1) && (stop_bits <= 2);
  endfunction

endpackage

// File: rtl/usart_baud_gen.sv
// Bit-period counter: ticks on the last cycle of every CLKS_PER_BIT-cycle
// period; a clear holds it at zero so the next period starts cleanly.
module usart_baud_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset || i_clear || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/usart_tx.sv
// USART transmitter: accepts a word on valid/ready and shifts out
// start, data LSB first, optional parity and stop bit(s) on a registered tx.
module usart_tx
  import usart_pkg::*;
#(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BIT  = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_BIT-1:0] tx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic                tx,
  output logic                tx_busy,
  output logic                tx_done,
  output usart_state_e        o_dbg_state
);

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_BIT - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);

  generate
    if (!usart_params_ok(CPB, DATA_BIT, PARITY, STOP_BITS)) begin : g_param_err
      $error("usart_tx: illegal parameter set");
    end
  endgenerate

  // Handshake: a word is accepted at a rising edge where tx_valid && tx_ready;
  // tx_ready is high only in IDLE while reset is released.
  usart_state_e          r_state;
  logic                  r_tx;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_par;
  logic [DATA_BIT-1:0]   r_shift;
  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  logic                  w_tick;
  logic                  w_accept;
  logic                  w_clear;

  assign tx_ready    = (r_state == ST_IDLE) && reset;
  assign w_accept    = tx_valid && tx_ready;
  assign w_clear     = (r_state == ST_IDLE);
  assign tx          = r_tx;
  assign tx_busy     = r_busy;
  assign tx_done     = r_done;
  assign o_dbg_state = r_state;

  usart_baud_gen #(.CLKS_PER_BIT(CPB)) u_baud (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_clear),
    .o_tick  (w_tick)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_par     <= 1'b0;
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_tx <= 1'b1;
          if (w_accept) begin
            r_state   <= ST_START;
            r_tx      <= 1'b0;
            r_busy    <= 1'b1;
            r_shift   <= tx_data;
            r_par     <= (PARITY == PAR_ODD) ? ~^tx_data : ^tx_data;
            r_bit_cnt <= '0;
          end
        end
        ST_START: begin
          if (w_tick) begin
            r_state   <= ST_DATA;
            r_tx      <= r_shift[0];
            r_bit_cnt <= '0;
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            r_shift <= r_shift >> 1;
            if (r_bit_cnt == LAST_DATA) begin
              r_bit_cnt <= '0;
              if (PARITY != PAR_NONE) begin
                r_state <= ST_PARITY;
                r_tx    <= r_par;
              end else begin
                r_state <= ST_STOP;
                r_tx    <= 1'b1;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_tx      <= r_shift[1];
            end
          end
        end
        ST_PARITY: begin
          if (w_tick) begin
            r_state   <= ST_STOP;
            r_tx      <= 1'b1;
            r_bit_cnt <= '0;
          end
        end
        ST_STOP: begin
          r_tx <= 1'b1;
          if (w_tick) begin
            if (r_bit_cnt == LAST_STOP) begin
              r_state   <= ST_IDLE;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_bit_cnt <= '0;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
